// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotating row strobe, 2-flop column synchronizer, press/release debounce.
// Optional macro KEYPAD_SCANNER_GHOST_REJECT_EN rejects multi-column samples instead of taking the lowest bit.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] rows,
  output logic [3:0] columns,
  output logic       key_valid,
  output logic       key_strobe,
  output logic [1:0] dbg_state_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       cs_q;
  logic [DIV_W-1:0] div_q;
  logic [DB_W-1:0]  db_q;
  logic [3:0]       cap_col_q;
  logic [3:0]       row_drive_q;
  logic [3:0]       rows_q;
  logic [3:0]       columns_q;
  logic             key_valid_q;
  logic             key_strobe_q;

  logic             cand_ok;
  logic [3:0]       cand_col;
  logic             press_match;
  logic             hit;
  logic [3:0]       row_next;

`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
  assign cand_ok     = (cs_q != 4'd0) && ((cs_q & (cs_q - 4'd1)) == 4'd0);
  assign cand_col    = cs_q;
  assign press_match = (cs_q == cap_col_q);
`else
  // Two's-complement trick isolates the lowest set column.
  assign cand_ok     = (cs_q != 4'd0);
  assign cand_col    = cs_q & (~cs_q + 4'd1);
  assign press_match = ((cs_q & cap_col_q) != 4'd0);
`endif

  assign hit      = ((cs_q & cap_col_q) != 4'd0);
  assign row_next = {row_drive_q[2:0], row_drive_q[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN;
      sync1_q      <= 4'd0;
      cs_q         <= 4'd0;
      div_q        <= '0;
      db_q         <= '0;
      cap_col_q    <= 4'd0;
      row_drive_q  <= 4'b0001;
      rows_q       <= 4'd0;
      columns_q    <= 4'd0;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      sync1_q      <= col_in;
      cs_q         <= sync1_q;
      key_strobe_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (cand_ok) begin
              cap_col_q <= cand_col;
              db_q      <= '0;
              state_q   <= PRESS_DB;
            end else begin
              row_drive_q <= row_next;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        PRESS_DB: begin
          if (press_match) begin
            if (db_q == DB_LAST) begin
              state_q      <= HELD;
              rows_q       <= row_drive_q;
              columns_q    <= cap_col_q;
              key_strobe_q <= 1'b1;
              key_valid_q  <= 1'b1;
            end else begin
              db_q <= db_q + DB_W'(1);
            end
          end else begin
            state_q     <= SCAN;
            row_drive_q <= row_next;
            div_q       <= '0;
          end
        end
        HELD: begin
          if (!hit) begin
            db_q    <= '0;
            state_q <= REL_DB;
          end
        end
        REL_DB: begin
          // A reasserting column restarts the release count but never re-enters HELD.
          if (hit) begin
            db_q <= '0;
          end else if (db_q == DB_LAST) begin
            state_q     <= SCAN;
            row_drive_q <= row_next;
            div_q       <= '0;
            key_valid_q <= 1'b0;
          end else begin
            db_q <= db_q + DB_W'(1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_drive   = row_drive_q;
  assign rows        = rows_q;
  assign columns     = columns_q;
  assign key_valid   = key_valid_q;
  assign key_strobe  = key_strobe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8) with a behavioural keypad model.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       key_valid;
  logic       key_strobe;
  logic [1:0] dbg_state;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .col_in      (col_in),
    .row_drive   (row_drive),
    .rows        (rows),
    .columns     (columns),
    .key_valid   (key_valid),
    .key_strobe  (key_strobe),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // keypad model: pressed key location, release cycle, and a glitch window that inverts the press
  logic [3:0] key_row;
  logic [3:0] key_col;
  int         rel_cyc;
  int         g_lo;
  int         g_hi;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0] key_row;
    logic [3:0] key_col;
    int         cyc;
    logic [3:0] row_drive;
    logic [3:0] rows;
    logic [3:0] columns;
    logic       valid;
    logic       strobe;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_col();
    logic pressed;
    pressed = ((key_row != 4'd0) && (cyc < rel_cyc)) ^ ((cyc >= g_lo) && (cyc <= g_hi));
    col_in = (pressed && ((row_drive & key_row) != 4'd0)) ? key_col : 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_col();
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    col_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    drive_col();
  endtask

  task automatic setup_key(input logic [3:0] r, input logic [3:0] c, input int rel,
                           input int lo, input int hi);
    key_row = r;
    key_col = c;
    rel_cyc = rel;
    g_lo    = lo;
    g_hi    = hi;
  endtask

  // scoreboard: every observed strobe must match the next expected strobe cycle
  task automatic watch_until(input int target);
    while (cyc < target) begin
      tick();
      if (key_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          check("strobe_cycle", 32'(cyc), exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic add_vec(input logic [3:0] kr, input logic [3:0] kc, input int c,
                         input logic [3:0] rd, input logic [3:0] r, input logic [3:0] co,
                         input logic v, input logic s);
    vec_t t;
    t.key_row = kr; t.key_col = kc; t.cyc = c;
    t.row_drive = rd; t.rows = r; t.columns = co; t.valid = v; t.strobe = s;
    vecs.push_back(t);
  endtask

  initial begin
    reset = 1'b1;
    col_in = 4'd0;
    setup_key(4'd0, 4'd0, 1000000, -1, -1);

    // idle scan: row advances every 4 cycles
    add_vec(4'b0000, 4'b0000,  0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0000, 4'b0000,  3, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0000, 4'b0000,  4, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0000, 4'b0000,  8, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0000, 4'b0000, 12, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0000, 4'b0000, 16, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0000, 4'b0000, 20, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // key at row 0010 / col 0100: sample point 7, strobe at 16
    add_vec(4'b0010, 4'b0100,  7, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0010, 4'b0100, 15, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0010, 4'b0100, 16, 4'b0010, 4'b0010, 4'b0100, 1'b1, 1'b1);
    add_vec(4'b0010, 4'b0100, 17, 4'b0010, 4'b0010, 4'b0100, 1'b1, 1'b0);
    add_vec(4'b0010, 4'b0100, 60, 4'b0010, 4'b0010, 4'b0100, 1'b1, 1'b0);
    // first and last rows
    add_vec(4'b0001, 4'b0001, 11, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0001, 4'b0001, 12, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1);
    add_vec(4'b1000, 4'b1000, 24, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1);
    // two columns on row 0001
`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
    add_vec(4'b0001, 4'b0011, 12, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_vec(4'b0001, 4'b0011, 30, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
`else
    add_vec(4'b0001, 4'b0011, 12, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1);
    add_vec(4'b0001, 4'b0011, 30, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      setup_key(vecs[i].key_row, vecs[i].key_col, 1000000, -1, -1);
      apply_reset();
      while (cyc < vecs[i].cyc) tick();
      check($sformatf("vec%0d_outs", i),
            32'({row_drive, rows, columns, key_valid, key_strobe}),
            32'({vecs[i].row_drive, vecs[i].rows, vecs[i].columns, vecs[i].valid, vecs[i].strobe}));
    end

    // press bounce: pin drops in cycle 10, scan resumes at row 0100, re-detect strobes at 37
    setup_key(4'b0010, 4'b0100, 1000000, 10, 10);
    apply_reset();
    exp_q.delete();
    exp_q.push_back(32'd37);
    watch_until(13);
    check("bounce_row_resume", 32'(row_drive), 32'(4'b0100));
    check("bounce_no_valid", 32'(key_valid), 32'd0);
    watch_until(60);
    check("bounce_strobe_count", 32'(exp_q.size()), 32'd0);
    check("bounce_key", 32'({rows, columns, key_valid}), 32'({4'b0010, 4'b0100, 1'b1}));

    // clean release: pin low from 30, cs low at 32, valid falls at 41
    setup_key(4'b0010, 4'b0100, 30, -1, -1);
    apply_reset();
    exp_q.delete();
    exp_q.push_back(32'd16);
    watch_until(40);
    check("release_valid_hold", 32'(key_valid), 32'd1);
    watch_until(41);
    check("release_valid_fall", 32'(key_valid), 32'd0);
    check("release_row_adv", 32'(row_drive), 32'(4'b0100));
    check("release_retain", 32'({rows, columns}), 32'({4'b0010, 4'b0100}));
    watch_until(70);
    check("release_strobe_count", 32'(exp_q.size()), 32'd0);

    // release bounce: pin reasserts 35..36 (cs 37..38), count restarts, valid falls at 47
    setup_key(4'b0010, 4'b0100, 30, 35, 36);
    apply_reset();
    exp_q.delete();
    exp_q.push_back(32'd16);
    watch_until(41);
    check("relbounce_valid_41", 32'(key_valid), 32'd1);
    watch_until(46);
    check("relbounce_valid_46", 32'(key_valid), 32'd1);
    watch_until(47);
    check("relbounce_valid_47", 32'(key_valid), 32'd0);
    watch_until(80);
    check("relbounce_strobe_count", 32'(exp_q.size()), 32'd0);

    // reset while HELD, then re-detection 16 cycles after reset release
    setup_key(4'b0010, 4'b0100, 1000000, -1, -1);
    apply_reset();
    exp_q.delete();
    exp_q.push_back(32'd16);
    watch_until(20);
    check("held_before_reset", 32'(key_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("reset_in_held", 32'({row_drive, rows, columns, key_valid, key_strobe}),
          32'({4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0}));
    reset = 1'b0;
    exp_q.push_back(32'd37);
    watch_until(60);
    check("redetect_strobe_count", 32'(exp_q.size()), 32'd0);
    check("redetect_key", 32'({rows, columns, key_valid}), 32'({4'b0010, 4'b0100, 1'b1}));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
